// File: rtl/score_counter.sv
// score_counter: packed-BCD game score engine with milestone pulse.
// Counts one point per TICKS_PER_POINT game ticks while a run is active,
// clears on start, freezes on game over and saturates at all nines.
// Optional high-score register is built when SCORE_HIGH_SCORE_EN is defined;
// otherwise o_high_score is tied to zero.
module score_counter #(
  parameter int unsigned NUM_DIGITS      = 4,
  parameter int unsigned TICKS_PER_POINT = 2,
  parameter int unsigned MILESTONE_DIGIT = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    i_game_tick,
  input  logic                    i_game_start,
  input  logic                    i_game_over,
  output logic [4*NUM_DIGITS-1:0] o_score,
  output logic                    o_running,
  output logic                    o_milestone,
  output logic [4*NUM_DIGITS-1:0] o_high_score
);

  localparam int unsigned SCORE_W = 4 * NUM_DIGITS;
  localparam int unsigned PRE_W   = 8;
  localparam logic [SCORE_W-1:0] SCORE_MAX = {NUM_DIGITS{4'h9}};
  localparam logic [PRE_W-1:0]   PRE_LAST  = PRE_W'(TICKS_PER_POINT - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUNNING = 2'd1,
    OVER    = 2'd2
  } state_t;

  state_t             state;
  state_t             state_next;
  logic [PRE_W-1:0]   prescaler;
  logic [PRE_W-1:0]   prescaler_next;
  logic [SCORE_W-1:0] score_next;
  logic [SCORE_W-1:0] score_inc;
  logic               milestone_next;
  logic               running_next;
  logic               carry;
  logic               carry_into_ms;

  // BCD ripple +1 of the current score; also reports a carry into the milestone digit
  always_comb begin
    score_inc     = o_score;
    carry         = 1'b1;
    carry_into_ms = 1'b0;
    for (int unsigned d = 0; d < NUM_DIGITS; d++) begin
      if (d == MILESTONE_DIGIT) begin
        carry_into_ms = carry;
      end
      if (carry) begin
        if (o_score[4*d +: 4] == 4'd9) begin
          score_inc[4*d +: 4] = 4'd0;
        end else begin
          score_inc[4*d +: 4] = o_score[4*d +: 4] + 4'd1;
          carry               = 1'b0;
        end
      end
    end
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; game over beats any simultaneous start while running
  always_comb begin
    state_next = state;
    unique case (state)
      IDLE, OVER: if (i_game_start) state_next = RUNNING;
      RUNNING:    if (i_game_over)  state_next = OVER;
      default:    state_next = IDLE;
    endcase
  end

  // Output/datapath next values: clear on start, count qualified ticks, hold otherwise
  always_comb begin
    score_next     = o_score;
    prescaler_next = prescaler;
    milestone_next = 1'b0;
    running_next   = (state_next == RUNNING);
    unique case (state)
      IDLE, OVER: begin
        if (i_game_start) begin
          score_next     = '0;
          prescaler_next = '0;
        end
      end
      RUNNING: begin
        if (i_game_over) begin
          score_next = o_score;
        end else if (i_game_start) begin
          score_next     = '0;
          prescaler_next = '0;
        end else if (i_game_tick) begin
          if (prescaler == PRE_LAST) begin
            prescaler_next = '0;
            if (o_score != SCORE_MAX) begin
              score_next     = score_inc;
              milestone_next = carry_into_ms;
            end
          end else begin
            prescaler_next = prescaler + PRE_W'(1);
          end
        end
      end
      default: begin
        score_next     = '0;
        prescaler_next = '0;
      end
    endcase
  end

  // Registered outputs and prescaler
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prescaler   <= '0;
      o_score     <= '0;
      o_running   <= 1'b0;
      o_milestone <= 1'b0;
    end else begin
      prescaler   <= prescaler_next;
      o_score     <= score_next;
      o_running   <= running_next;
      o_milestone <= milestone_next;
    end
  end

`ifdef SCORE_HIGH_SCORE_EN
  // High score captures the frozen score in the first OVER cycle; packed BCD orders like decimal
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_high_score <= '0;
    end else if ((state == OVER) && (o_score > o_high_score)) begin
      o_high_score <= o_score;
    end
  end
`else
  assign o_high_score = '0;
`endif

endmodule

// File: tb/tb_score_counter.sv
// tb_score_counter: scoreboard bench for score_counter.
// A decimal reference model predicts every cycle's outputs; predictions are
// queued when inputs are driven and compared after the following clock edge.
module tb_score_counter;

  localparam int unsigned ND  = 4;
  localparam int unsigned TPP = 2;
  localparam int unsigned MSD = 2;
  localparam int MS_MOD = 100;
  localparam int MAX_SCORE = 9999;

  logic        clk;
  logic        rst;
  logic        i_game_tick;
  logic        i_game_start;
  logic        i_game_over;
  logic [15:0] o_score;
  logic        o_running;
  logic        o_milestone;
  logic [15:0] o_high_score;

  score_counter #(
    .NUM_DIGITS      (ND),
    .TICKS_PER_POINT (TPP),
    .MILESTONE_DIGIT (MSD)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .i_game_tick  (i_game_tick),
    .i_game_start (i_game_start),
    .i_game_over  (i_game_over),
    .o_score      (o_score),
    .o_running    (o_running),
    .o_milestone  (o_milestone),
    .o_high_score (o_high_score)
  );

  typedef struct {
    logic [15:0] score;
    logic        running;
    logic        milestone;
    logic [15:0] high;
  } exp_t;

  exp_t q[$];

  int n_checks = 0;
  int n_fail   = 0;
  int ms_seen  = 0;

  // reference model: 0 idle, 1 running, 2 over
  int m_state;
  int m_score;
  int m_pre;
  int m_hs;
  bit m_hs_pend;
  bit m_ms;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int v);
    logic [15:0] r;
    int x;
    x = v;
    for (int i = 0; i < 4; i++) begin
      r[4*i +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  task automatic model_reset();
    m_state   = 0;
    m_score   = 0;
    m_pre     = 0;
    m_hs      = 0;
    m_hs_pend = 1'b0;
    m_ms      = 1'b0;
  endtask

  task automatic model_step(input bit t, input bit s, input bit o);
    m_ms = 1'b0;
    if (m_hs_pend) begin
      if (m_score > m_hs) m_hs = m_score;
      m_hs_pend = 1'b0;
    end
    if (m_state == 1) begin
      if (o) begin
        m_state   = 2;
        m_hs_pend = 1'b1;
      end else if (s) begin
        m_score = 0;
        m_pre   = 0;
      end else if (t) begin
        if (m_pre == int'(TPP) - 1) begin
          m_pre = 0;
          if (m_score < MAX_SCORE) begin
            if (m_score % MS_MOD == MS_MOD - 1) m_ms = 1'b1;
            m_score++;
          end
        end else begin
          m_pre++;
        end
      end
    end else if (s) begin
      m_state = 1;
      m_score = 0;
      m_pre   = 0;
    end
  endtask

  function automatic logic [15:0] exp_high();
`ifdef SCORE_HIGH_SCORE_EN
    return to_bcd(m_hs);
`else
    return 16'h0000;
`endif
  endfunction

  // drive one cycle, queue the prediction, then compare after the edge
  task automatic cycle(input bit t, input bit s, input bit o);
    exp_t e;
    i_game_tick  = t;
    i_game_start = s;
    i_game_over  = o;
    model_step(t, s, o);
    e.score     = to_bcd(m_score);
    e.running   = (m_state == 1);
    e.milestone = m_ms;
    e.high      = exp_high();
    q.push_back(e);
    @(posedge clk);
    #1;
    i_game_tick  = 1'b0;
    i_game_start = 1'b0;
    i_game_over  = 1'b0;
    if (o_milestone) ms_seen++;
    if (q.size() == 0) begin
      check("queue_empty", 32'd1, 32'd0);
    end else begin
      e = q.pop_front();
      check("score",     32'(o_score),      32'(e.score));
      check("running",   32'(o_running),    32'(e.running));
      check("milestone", 32'(o_milestone),  32'(e.milestone));
      check("high",      32'(o_high_score), 32'(e.high));
    end
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) cycle(1'b1, 1'b0, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst          = 1'b1;
    i_game_tick  = 1'b0;
    i_game_start = 1'b0;
    i_game_over  = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("rst_score",   32'(o_score),      32'h0000);
    check("rst_running", 32'(o_running),    32'h0);
    check("rst_ms",      32'(o_milestone),  32'h0);
    check("rst_high",    32'(o_high_score), 32'h0000);
    rst = 1'b0;

    // ticks and over are ignored in IDLE
    ticks(3);
    cycle(1'b0, 1'b0, 1'b1);

    // start then 10 ticks -> 5 points
    cycle(1'b0, 1'b1, 1'b0);
    ticks(10);
    check("t2_score", 32'(o_score), 32'h0005);

    // reach 7 with prescaler at 1, then tick+over together
    ticks(5);
    cycle(1'b1, 1'b0, 1'b1);
    check("t5_score",   32'(o_score),   32'h0007);
    check("t5_running", 32'(o_running), 32'h0);
    ticks(6);
    check("t5_hold", 32'(o_score), 32'h0007);

    // high score: 42 then 13, restart keeps the best
    cycle(1'b0, 1'b1, 1'b0);
    ticks(84);
    check("t6_42", 32'(o_score), 32'h0042);
    cycle(1'b0, 1'b0, 1'b1);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(26);
    cycle(1'b0, 1'b0, 1'b1);
    idle(3);
    cycle(1'b0, 1'b1, 1'b0);
    idle(2);
    check("t6_score0", 32'(o_score), 32'h0000);
`ifdef SCORE_HIGH_SCORE_EN
    check("t6_high", 32'(o_high_score), 32'h0042);
`else
    check("t6_high", 32'(o_high_score), 32'h0000);
`endif

    // restart while running, start+over, start+tick from OVER
    ticks(7);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(3);
    cycle(1'b0, 1'b1, 1'b1);
    cycle(1'b1, 1'b1, 1'b0);
    check("start_tick", 32'(o_score), 32'h0000);
    ticks(1);
    check("pre_cleared", 32'(o_score), 32'h0000);
    ticks(1);
    check("first_point", 32'(o_score), 32'h0001);

    // milestone at 0099 -> 0100, then saturation at 9999
    cycle(1'b0, 1'b1, 1'b0);
    ms_seen = 0;
    ticks(198);
    check("t3_99", 32'(o_score), 32'h0099);
    ticks(1);
    ticks(1);
    check("t3_100",   32'(o_score),     32'h0100);
    check("t3_ms_on", 32'(o_milestone), 32'h1);
    ticks(1);
    check("t3_ms_off", 32'(o_milestone), 32'h0);
    ticks(19996 - 201);
    check("t4_9998", 32'(o_score), 32'h9998);
    ticks(6);
    check("t4_9999", 32'(o_score), 32'h9999);
    check("ms_count", 32'(ms_seen), 32'd99);
    cycle(1'b0, 1'b0, 1'b1);
    idle(2);

    // asynchronous reset mid-run clears everything including the high score
    cycle(1'b0, 1'b1, 1'b0);
    ticks(9);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check("mid_rst_score",   32'(o_score),      32'h0000);
    check("mid_rst_running", 32'(o_running),    32'h0);
    check("mid_rst_high",    32'(o_high_score), 32'h0000);
    model_reset();
    @(posedge clk);
    #1;
    rst = 1'b0;
    ticks(4);
    cycle(1'b0, 1'b1, 1'b0);
    ticks(4);
    check("post_rst", 32'(o_score), 32'h0002);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
